// File: rtl/tnn_feature_framer.sv
// tnn_feature_framer: gathers N_FEAT quantised features from a valid/ready
// stream into a parallel frame for a combinational TNN classifier, holds the
// frame stable for one evaluation cycle, then returns the registered verdict
// on a valid/ready result port with a frame-length error flag.
// Optional: define TNN_FRAMER_STATS_EN to add saturating result counters
// (stat_tot = frames completed, stat_pos = frames classified 1).
module tnn_feature_framer #(
  parameter int N_FEAT = 8,
  parameter int FEAT_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic [N_FEAT*FEAT_W-1:0] feat_bus,
  input  logic                     cls_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_class,
  output logic                     m_err
`ifdef TNN_FRAMER_STATS_EN
  ,
  output logic [CNT_W-1:0]         stat_pos,
  output logic [CNT_W-1:0]         stat_tot
`endif
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] EVAL    = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             beat, res, last_slot;

  assign beat      = s_valid && s_ready;
  assign res       = m_valid && m_ready;
  assign last_slot = (idx == IDX_W'(N_FEAT - 1));

  // Next-state: collection ends on s_last or runs into DRAIN when the frame overflows.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (beat) begin
          if (s_last)         state_nxt = EVAL;
          else if (last_slot) state_nxt = DRAIN;
        end
      end
      DRAIN:   if (beat && s_last) state_nxt = EVAL;
      EVAL:    state_nxt = OUT;
      OUT:     if (res) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // State, registered s_ready (depends only on next state, never on s_valid),
  // frame slots, and the result payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      s_ready  <= 1'b0;
      idx      <= '0;
      feat_bus <= '0;
      m_valid  <= 1'b0;
      m_class  <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == COLLECT) || (state_nxt == DRAIN);
      case (state)
        COLLECT: begin
          if (beat) begin
            // Write the current slot; a short frame zero-pads the remaining slots.
            for (int k = 0; k < N_FEAT; k++) begin
              if (k == int'(idx))
                feat_bus[k*FEAT_W +: FEAT_W] <= s_data;
              else if (s_last && (k > int'(idx)))
                feat_bus[k*FEAT_W +: FEAT_W] <= '0;
            end
            if (!last_slot) idx <= idx + 1'b1;
            // Error unless the frame ends exactly on the last slot.
            if (s_last || last_slot) m_err <= !(s_last && last_slot);
          end
        end
        EVAL: begin
          m_class <= cls_in;
          m_valid <= 1'b1;
        end
        OUT: begin
          if (res) begin
            m_valid <= 1'b0;
            idx     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TNN_FRAMER_STATS_EN
  // Saturating result counters, advanced on each result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_tot <= '0;
      stat_pos <= '0;
    end else if (res) begin
      if (stat_tot != '1)            stat_tot <= stat_tot + 1'b1;
      if (m_class && stat_pos != '1) stat_pos <= stat_pos + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tnn_feature_framer.sv
// Bench for tnn_feature_framer: directed frames (nominal, short, long,
// backpressure, mid-frame reset) followed by random frames, all checked
// against a frame-level reference model.
module tb_tnn_feature_framer;
  localparam int N = 8;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   s_data = '0;
  logic           s_last = 1'b0;
  logic [N*W-1:0] feat_bus;
  logic           cls_in;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic           m_class;
  logic           m_err;
`ifdef TNN_FRAMER_STATS_EN
  logic [15:0]    stat_pos, stat_tot;
`endif

  int compared   = 0;
  int mismatched = 0;
  int force_cls  = -1;
  int mdl_tot    = 0;
  int mdl_pos    = 0;
  logic [W-1:0] fq[$];

  tnn_feature_framer #(.N_FEAT(N), .FEAT_W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .feat_bus(feat_bus), .cls_in(cls_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_err(m_err)
`ifdef TNN_FRAMER_STATS_EN
    , .stat_pos(stat_pos), .stat_tot(stat_tot)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in classifier: an arbitrary combinational function of the frame.
  function automatic logic cls_fn(input logic [N*W-1:0] b);
    int s;
    s = int'(b[1:0]) + int'(b[7:6]) + int'(b[15:14]);
    return (s > 4) ^ b[10];
  endfunction

  always_comb cls_in = (force_cls < 0) ? cls_fn(feat_bus) : force_cls[0];

  // Reference frame: first N beats in order, slots past the frame length are zero.
  function automatic logic [N*W-1:0] ref_frame();
    logic [N*W-1:0] e;
    e = '0;
    for (int k = 0; k < N; k++)
      if (k < fq.size()) e[k*W +: W] = fq[k];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_feat_bus", feat_bus, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_m_class", m_class, 0);
`ifdef TNN_FRAMER_STATS_EN
    chk("rst_stat_tot", stat_tot, 0);
    chk("rst_stat_pos", stat_pos, 0);
`endif
    mdl_tot = 0; mdl_pos = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);
  endtask

  // Send fq as beats; s_last on the final beat only if mark_last.
  task automatic send_beats(input bit mark_last, input bit gaps);
    int n;
    for (int i = 0; i < fq.size(); i++) begin
      if (i != 0) @(negedge clk);
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      n = 0;
      while (!s_ready && n < 20) begin @(negedge clk); n++; end
      chk("s_ready_wait", s_ready, 1);
      s_valid = 1'b1;
      s_data  = fq[i];
      s_last  = mark_last && (i == fq.size() - 1);
      @(posedge clk);
    end
  endtask

  // Called right after the final beat's accepting edge (cycle t).
  task automatic check_result(input int stall);
    logic [N*W-1:0] eb;
    logic ec, ee;
    eb = ref_frame();
    ee = (fq.size() != N);
    ec = (force_cls < 0) ? cls_fn(eb) : force_cls[0];
    @(negedge clk);                       // t+1: evaluation cycle
    s_valid = 1'b0; s_last = 1'b0;
    chk("eval_m_valid", m_valid, 0);
    chk("eval_s_ready", s_ready, 0);
    chk("eval_feat_bus", feat_bus, eb);
    @(negedge clk);                       // t+2: result presented
    chk("out_m_valid", m_valid, 1);
    chk("out_m_class", m_class, ec);
    chk("out_m_err", m_err, ee);
    chk("out_feat_bus", feat_bus, eb);
    chk("out_s_ready", s_ready, 0);
    for (int c = 1; c < stall; c++) begin
      @(negedge clk);
      chk("hold_m_valid", m_valid, 1);
      chk("hold_m_class", m_class, ec);
      chk("hold_m_err", m_err, ee);
      chk("hold_feat_bus", feat_bus, eb);
      chk("hold_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    mdl_tot++;
    if (ec) mdl_pos++;
    chk("hs_m_valid", m_valid, 0);
    chk("hs_s_ready", s_ready, 1);
`ifdef TNN_FRAMER_STATS_EN
    chk("stat_tot", stat_tot, mdl_tot);
    chk("stat_pos", stat_pos, mdl_pos);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Nominal frame 0,1,2,3,3,2,1,0 -> 16'h1BE4
    fq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    send_beats(1'b1, 1'b0);
    check_result(0);

    // Short frame 3,3,3 -> 16'h003F, error
    fq = '{2'd3, 2'd3, 2'd3};
    send_beats(1'b1, 1'b0);
    check_result(0);

    // Long frame of 10 beats: last two dropped, error
    fq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd2};
    send_beats(1'b1, 1'b0);
    check_result(0);

    // Backpressure: m_ready low for 5 OUT cycles, handshake on the 6th
    fq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd3};
    send_beats(1'b1, 1'b0);
    check_result(6);

    // Mid-frame reset after 4 beats, then a clean full frame
    fq = '{2'd2, 2'd2, 2'd2, 2'd2};
    send_beats(1'b0, 1'b0);
    do_reset();
    fq = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    send_beats(1'b1, 1'b0);
    check_result(0);

`ifdef TNN_FRAMER_STATS_EN
    // Classifier forced to 1,0,1 over three frames after reset
    do_reset();
    for (int f = 0; f < 3; f++) begin
      force_cls = (f == 1) ? 0 : 1;
      fq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
      send_beats(1'b1, 1'b0);
      check_result(0);
    end
    chk("stat_tot_3", stat_tot, 3);
    chk("stat_pos_2", stat_pos, 2);
    force_cls = -1;
`endif

    // Random frames: lengths 1..11, random data, gaps and stalls
    for (int f = 0; f < 16; f++) begin
      int len;
      len = $urandom_range(1, 11);
      fq.delete();
      for (int i = 0; i < len; i++) fq.push_back(2'($urandom_range(0, 3)));
      send_beats(1'b1, 1'($urandom_range(0, 1)));
      check_result($urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
